// File: rtl/wb_stage_multi_if.sv
// Bundle/port interface for the multi-lane MEM->WB write-back stage.
// The master modport drives bundles and pipeline control. The slave modport is the stage itself.
interface wb_stage_multi_if #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RETIRE_W = 32
);
  logic                      stall;
  logic                      flush;
  logic [LANES-1:0]          in_valid;
  logic [LANES-1:0]          in_regWr;
  logic [LANES*ADDR_W-1:0]   in_regAddr;
  logic [LANES*DATA_W-1:0]   in_regData;
  logic [LANES*32-1:0]       in_inst_debug;
  logic [LANES*32-1:0]       in_pc_debug;
  logic [LANES-1:0]          we;
  logic [LANES*ADDR_W-1:0]   wAddr;
  logic [LANES*DATA_W-1:0]   wData;
  logic [LANES-1:0]          wbu_regWr;
  logic [LANES*ADDR_W-1:0]   wbu_regAddr;
  logic [LANES*DATA_W-1:0]   wbu_data;
  logic [RETIRE_W-1:0]       retire_cnt;
  logic [LANES*32-1:0]       wb_pc_debug;
  logic [LANES*32-1:0]       wb_inst_debug;

  modport master (
    output stall, flush, in_valid, in_regWr, in_regAddr, in_regData, in_inst_debug, in_pc_debug,
    input  we, wAddr, wData, wbu_regWr, wbu_regAddr, wbu_data, retire_cnt, wb_pc_debug, wb_inst_debug
  );
  modport slave (
    input  stall, flush, in_valid, in_regWr, in_regAddr, in_regData, in_inst_debug, in_pc_debug,
    output we, wAddr, wData, wbu_regWr, wbu_regAddr, wbu_data, retire_cnt, wb_pc_debug, wb_inst_debug
  );
endinterface

// File: rtl/wb_stage_multi.sv
// Multi-lane MIPS write-back stage: registers LANES MEM->WB bundles and drives one RF write port per lane.
// It also handles stall hold, flush, $zero suppression, the youngest-lane-wins ordering rule and the retire counter.
module wb_stage_multi #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RETIRE_W = 32
) (
  input logic             clk,
  input logic             rst,
  wb_stage_multi_if.slave bus
);
  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES-1:0]        regwr_q, regwr_d;
  logic [LANES*ADDR_W-1:0] addr_q, addr_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES*32-1:0]     inst_q, inst_d;
  logic [LANES*32-1:0]     pc_q, pc_d;
  logic                    fired_q, fired_d;
  logic [RETIRE_W-1:0]     retire_q, retire_d;
  logic [RETIRE_W-1:0]     retire_inc;
  logic [LANES-1:0]        live, kill, wr;

  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    fired_d = fired_q;
    if (bus.flush) begin
      valid_d = '0;
      fired_d = 1'b0;
    end else if (bus.stall) begin
      // After the first held cycle the bundle has already written the RF.
      fired_d = fired_q | (|valid_q);
    end else begin
      valid_d = bus.in_valid;
      regwr_d = bus.in_regWr;
      addr_d  = bus.in_regAddr;
      data_d  = bus.in_regData;
      inst_d  = bus.in_inst_debug;
      pc_d    = bus.in_pc_debug;
      fired_d = 1'b0;
    end
  end

  // A bundle is counted once, in its first WB cycle. This also applies when that cycle is flushed.
  always_comb begin
    retire_inc = '0;
    for (int unsigned i = 0; i < LANES; i++)
      retire_inc = retire_inc + RETIRE_W'(valid_q[i]);
    retire_d = fired_q ? retire_q : retire_q + retire_inc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= '0;
      regwr_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      inst_q   <= '0;
      pc_q     <= '0;
      fired_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      valid_q  <= valid_d;
      regwr_q  <= regwr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      fired_q  <= fired_d;
      retire_q <= retire_d;
    end
  end

  // Within a bundle, a younger lane writing the same register shadows the older lanes.
  always_comb begin
    live = '0;
    kill = '0;
    for (int unsigned i = 0; i < LANES; i++)
      live[i] = valid_q[i] & regwr_q[i] & (addr_q[i*ADDR_W +: ADDR_W] != '0);
    for (int unsigned i = 0; i < LANES; i++)
      for (int unsigned j = i + 1; j < LANES; j++)
        if (live[j] && (addr_q[j*ADDR_W +: ADDR_W] == addr_q[i*ADDR_W +: ADDR_W]))
          kill[i] = 1'b1;
    wr = live & ~kill;
  end

  assign bus.wbu_regWr     = wr;
  assign bus.we            = wr & {LANES{~fired_q}};
  assign bus.wAddr         = addr_q;
  assign bus.wData         = data_q;
  assign bus.wbu_regAddr   = addr_q;
  assign bus.wbu_data      = data_q;
  assign bus.retire_cnt    = retire_q;
  assign bus.wb_pc_debug   = pc_q;
  assign bus.wb_inst_debug = inst_q;
endmodule
